// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer: bus-master sclk/lrclk generation, stereo capture, valid/ready output buffer.
// Optional peak meter (peak_clr input, peak output) is enabled by defining I2S_RX_PEAK_EN.
module i2s_rx_deserializer #(
    parameter int SCLK_DIV = 4,
    parameter int WORD_W   = 16,
    parameter int SLOT_W   = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     sdin,
    output logic                     sclk,
    output logic                     lrclk,
    output logic signed [WORD_W-1:0] left_word,
    output logic signed [WORD_W-1:0] right_word,
    output logic                     valid,
    input  logic                     ready,
    output logic                     overflow,
    input  logic                     overflow_clr
`ifdef I2S_RX_PEAK_EN
    ,
    input  logic                     peak_clr,
    output logic        [WORD_W-1:0] peak
`endif
);

    localparam int DIV_W = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
    localparam int BIT_W = $clog2(2 * SLOT_W);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(SCLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(2 * SLOT_W - 1);
    localparam logic [BIT_W-1:0] SLOT_POS  = BIT_W'(SLOT_W);
    localparam logic [BIT_W-1:0] WORD_LAST = BIT_W'(WORD_W);
    localparam logic [BIT_W-1:0] DONE_POS  = BIT_W'(SLOT_W + WORD_W);

    logic [DIV_W-1:0]         div_cnt_q, div_cnt_d;
    logic                     sclk_q, sclk_d;
    logic [BIT_W-1:0]         bit_cnt_q, bit_cnt_d;
    logic signed [WORD_W-1:0] left_sr_q, left_sr_d;
    logic signed [WORD_W-1:0] right_sr_q, right_sr_d;
    logic                     frame_done_q, frame_done_d;
    logic signed [WORD_W-1:0] left_q, left_d;
    logic signed [WORD_W-1:0] right_q, right_d;
    logic                     valid_q, valid_d;
    logic                     ovf_q, ovf_d;
    logic                     load, drop;

    logic             tick, rise, fall, in_right, in_word;
    logic [BIT_W-1:0] pos;

    assign tick     = en && (div_cnt_q == DIV_LAST);
    assign rise     = tick && !sclk_q;
    assign fall     = tick && sclk_q;
    assign in_right = (bit_cnt_q >= SLOT_POS);
    assign pos      = in_right ? (bit_cnt_q - SLOT_POS) : bit_cnt_q;
    // Slot position 0 is the I2S one-bit delay; positions past the word are padding.
    assign in_word  = (pos != '0) && (pos <= WORD_LAST);

    always_comb begin
        div_cnt_d    = div_cnt_q;
        sclk_d       = sclk_q;
        bit_cnt_d    = bit_cnt_q;
        left_sr_d    = left_sr_q;
        right_sr_d   = right_sr_q;
        frame_done_d = 1'b0;
        if (!en) begin
            div_cnt_d  = '0;
            sclk_d     = 1'b0;
            bit_cnt_d  = '0;
            left_sr_d  = '0;
            right_sr_d = '0;
        end else begin
            if (tick) begin
                div_cnt_d = '0;
                sclk_d    = !sclk_q;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
            if (fall) begin
                bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + 1'b1;
            end
            if (rise && in_word) begin
                if (in_right) begin
                    right_sr_d = {right_sr_q[WORD_W-2:0], sdin};
                end else begin
                    left_sr_d = {left_sr_q[WORD_W-2:0], sdin};
                end
            end
            if (rise && (bit_cnt_q == DONE_POS)) begin
                frame_done_d = 1'b1;
            end
        end
    end

    // Output buffer: a completed frame loads if the slot is free or being consumed this cycle.
    always_comb begin
        load    = frame_done_q && (!valid_q || ready);
        drop    = frame_done_q && valid_q && !ready;
        valid_d = valid_q;
        left_d  = left_q;
        right_d = right_q;
        if (load) begin
            valid_d = 1'b1;
            left_d  = left_sr_q;
            right_d = right_sr_q;
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
        if (drop) begin
            ovf_d = 1'b1;
        end else if (overflow_clr) begin
            ovf_d = 1'b0;
        end else begin
            ovf_d = ovf_q;
        end
    end

`ifdef I2S_RX_PEAK_EN
    localparam logic [WORD_W-1:0] MIN_NEG = {1'b1, {(WORD_W-1){1'b0}}};
    localparam logic [WORD_W-1:0] MAX_POS = {1'b0, {(WORD_W-1){1'b1}}};

    function automatic logic [WORD_W-1:0] abs_sat(input logic signed [WORD_W-1:0] x);
        logic [WORD_W-1:0] mag;
        if (x == MIN_NEG) begin
            mag = MAX_POS;
        end else if (x < 0) begin
            mag = $unsigned(-x);
        end else begin
            mag = $unsigned(x);
        end
        return mag;
    endfunction

    logic [WORD_W-1:0] peak_q, peak_d;
    logic [WORD_W-1:0] mag_l, mag_r, mag_frame;

    assign mag_l     = abs_sat(left_sr_q);
    assign mag_r     = abs_sat(right_sr_q);
    assign mag_frame = (mag_l > mag_r) ? mag_l : mag_r;

    always_comb begin
        peak_d = peak_q;
        if (load) begin
            if (peak_clr || (mag_frame > peak_q)) begin
                peak_d = mag_frame;
            end
        end else if (peak_clr) begin
            peak_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            peak_q <= '0;
        end else begin
            peak_q <= peak_d;
        end
    end

    assign peak = peak_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            sclk_q       <= 1'b0;
            bit_cnt_q    <= '0;
            left_sr_q    <= '0;
            right_sr_q   <= '0;
            frame_done_q <= 1'b0;
            left_q       <= '0;
            right_q      <= '0;
            valid_q      <= 1'b0;
            ovf_q        <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            sclk_q       <= sclk_d;
            bit_cnt_q    <= bit_cnt_d;
            left_sr_q    <= left_sr_d;
            right_sr_q   <= right_sr_d;
            frame_done_q <= frame_done_d;
            left_q       <= left_d;
            right_q      <= right_d;
            valid_q      <= valid_d;
            ovf_q        <= ovf_d;
        end
    end

    assign sclk       = en && sclk_q;
    assign lrclk      = en && in_right;
    assign left_word  = left_q;
    assign right_word = right_q;
    assign valid      = valid_q;
    assign overflow   = ovf_q;

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Randomized self-checking bench for i2s_rx_deserializer against a timeline-based frame model.
// Define I2S_RX_PEAK_EN for both files to exercise the optional peak meter.
module tb_i2s_rx_deserializer;

    localparam int D = 4;
    localparam int W = 16;
    localparam int S = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic en = 1'b0;
    logic sdin = 1'b0;
    logic ready = 1'b0;
    logic overflow_clr = 1'b0;
    logic sclk, lrclk, valid, overflow;
    logic signed [W-1:0] left_word, right_word;
`ifdef I2S_RX_PEAK_EN
    logic peak_clr = 1'b0;
    logic [W-1:0] peak;
    logic [W-1:0] ep;
`endif

    always #5 clk = ~clk;

    i2s_rx_deserializer #(.SCLK_DIV(D), .WORD_W(W), .SLOT_W(S)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .en(en),
        .sdin(sdin),
        .sclk(sclk),
        .lrclk(lrclk),
        .left_word(left_word),
        .right_word(right_word),
        .valid(valid),
        .ready(ready),
        .overflow(overflow),
        .overflow_clr(overflow_clr)
`ifdef I2S_RX_PEAK_EN
        ,
        .peak_clr(peak_clr),
        .peak(peak)
`endif
    );

    // Model state: n = clk edges since capture (re)started with en=1.
    int vectors = 0;
    int miscompares = 0;
    int n = 0;
    int pad_mode = 0;
    bit pend = 1'b0;
    bit ev = 1'b0;
    bit eo = 1'b0;
    logic [W-1:0] pl, pr;
    logic [W-1:0] el = '0;
    logic [W-1:0] er = '0;
    logic [W-1:0] fl [16];
    logic [W-1:0] fr [16];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s n=%0d: got %h, expected %h", name, n, act, exp);
        end
    endtask

    function automatic int amag(input logic [W-1:0] x);
        int v;
        v = $signed(x);
        if (v < 0) v = -v;
        if (v > (1 << (W - 1)) - 1) v = (1 << (W - 1)) - 1;
        return v;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 16; i++) begin
            fl[i] = W'($urandom);
            fr[i] = W'($urandom);
        end
    endtask

    // One clk cycle: drive sdin for the coming edge, advance the model, compare after the edge.
    task automatic cycle();
        int m, k, pos, p;
        logic [W-1:0] w;
        bit ld, drp;
        m = n + 1;
        sdin = 1'($urandom);
        if (en && m >= D && (m - D) % (2 * D) == 0) begin
            k = (m - D) / (2 * D);
            pos = k % (2 * S);
            p = pos % S;
            if (p >= 1 && p <= W) begin
                w = (pos >= S) ? fr[(k / (2 * S)) % 16] : fl[(k / (2 * S)) % 16];
                sdin = w[W - p];
            end else begin
                sdin = (pad_mode == 2) ? 1'($urandom) : 1'(pad_mode);
            end
        end
        ld = pend && (!ev || ready);
        drp = pend && ev && !ready;
`ifdef I2S_RX_PEAK_EN
        begin
            int mg;
            mg = (amag(pl) > amag(pr)) ? amag(pl) : amag(pr);
            if (ld) ep = (peak_clr || W'(mg) > ep) ? W'(mg) : ep;
            else if (peak_clr) ep = '0;
        end
`endif
        if (ld) begin
            ev = 1'b1;
            el = pl;
            er = pr;
        end else if (ev && ready) begin
            ev = 1'b0;
        end
        if (drp) eo = 1'b1;
        else if (overflow_clr) eo = 1'b0;
        if (en) begin
            n = m;
            pend = (n >= D) && ((n - D) % (2 * D) == 0) && (((n - D) / (2 * D)) % (2 * S) == S + W);
            if (pend) begin
                k = ((n - D) / (2 * D)) / (2 * S);
                pl = fl[k % 16];
                pr = fr[k % 16];
            end
        end else begin
            n = 0;
            pend = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        chk("sclk", W'(sclk), W'(en && ((n / D) % 2 == 1)));
        chk("lrclk", W'(lrclk), W'(en && ((n / (2 * D)) % (2 * S) >= S)));
        chk("valid", W'(valid), W'(ev));
        chk("overflow", W'(overflow), W'(eo));
        chk("left_word", left_word, el);
        chk("right_word", right_word, er);
`ifdef I2S_RX_PEAK_EN
        chk("peak", peak, ep);
`endif
    endtask

    task automatic run_to(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 20000) begin
            cycle();
            guard++;
        end
        if (n < target) begin
            miscompares++;
            vectors++;
            $display("FAIL run_to: reached n=%0d, required %0d", n, target);
        end
    endtask

    task automatic restart();
        en = 1'b0;
        cycle();
        en = 1'b1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_sclk"}, W'(sclk), '0);
        chk({tag, "_lrclk"}, W'(lrclk), '0);
        chk({tag, "_left"}, left_word, '0);
        chk({tag, "_right"}, right_word, '0);
        chk({tag, "_valid"}, W'(valid), '0);
        chk({tag, "_overflow"}, W'(overflow), '0);
    endtask

    task automatic model_reset();
        n = 0;
        pend = 1'b0;
        ev = 1'b0;
        eo = 1'b0;
        el = '0;
        er = '0;
`ifdef I2S_RX_PEAK_EN
        ep = '0;
`endif
    endtask

    initial begin
        int bias, off;
        fill_random();
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("por");
        model_reset();
        en = 1'b1;
        rst_n = 1'b1;

        // Basic capture and timing pins
        fl[0] = 16'hA5C3;
        fr[0] = 16'h1234;
        ready = 1'b1;
        pad_mode = 0;
        run_to(3);
        chk("first_rise_e3", W'(sclk), 16'd0);
        run_to(4);
        chk("first_rise_e4", W'(sclk), 16'd1);
        chk("first_lrclk", W'(lrclk), 16'd0);
        run_to(388);
        chk("basic_pre_valid", W'(valid), 16'd0);
        run_to(389);
        chk("basic_valid", W'(valid), 16'd1);
        chk("basic_left", left_word, 16'hA5C3);
        chk("basic_right", right_word, 16'h1234);
        run_to(390);
        chk("basic_valid_1clk", W'(valid), 16'd0);
        chk("basic_hold_left", left_word, 16'hA5C3);
        run_to(900);
        chk("period_pre", W'(valid), 16'd0);
        run_to(901);
        chk("period_valid", W'(valid), 16'd1);

        // Padding bits driven high are ignored
        fl[0] = 16'h8000;
        fr[0] = 16'h0001;
        pad_mode = 1;
        restart();
        run_to(389);
        chk("pad_left", left_word, 16'h8000);
        chk("pad_right", right_word, 16'h0001);

        // Backpressure across two frames, then overflow clear
        restart();
        ready = 1'b0;
        pad_mode = 2;
        fl[0] = 16'h1111; fr[0] = 16'h2222;
        fl[1] = 16'h3333; fr[1] = 16'h4444;
        fl[2] = 16'h5555; fr[2] = 16'h6666;
        run_to(902);
        chk("bp_valid", W'(valid), 16'd1);
        chk("bp_left", left_word, 16'h1111);
        chk("bp_right", right_word, 16'h2222);
        chk("bp_overflow", W'(overflow), 16'd1);
        overflow_clr = 1'b1;
        cycle();
        overflow_clr = 1'b0;
        chk("ovf_clr", W'(overflow), 16'd0);

        // Handshake coincides with the next load
        run_to(1412);
        ready = 1'b1;
        cycle();
        chk("sim_valid", W'(valid), 16'd1);
        chk("sim_left", left_word, 16'h5555);
        chk("sim_right", right_word, 16'h6666);
        chk("sim_overflow", W'(overflow), 16'd0);
        cycle();

        // Randomized traffic with varying backpressure and one enable gap
        fill_random();
        restart();
        off = $urandom_range(1, 40);
        bias = 4;
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) bias = $urandom_range(0, 4);
            ready = (int'($urandom_range(0, 3)) < bias);
            overflow_clr = ($urandom_range(0, 63) == 0);
            en = !(i >= 1500 && i < 1500 + off);
            cycle();
        end
        overflow_clr = 1'b0;
        en = 1'b1;

        // Asynchronous reset at an arbitrary phase mid-frame
        repeat ($urandom_range(50, 300)) cycle();
        #($urandom_range(1, 4));
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async");
        @(negedge clk);
        @(negedge clk);
        model_reset();
        fill_random();
        rst_n = 1'b1;
        ready = 1'b1;
        run_to(3);
        chk("rst_rise_e3", W'(sclk), 16'd0);
        run_to(4);
        chk("rst_rise_e4", W'(sclk), 16'd1);
        chk("rst_lrclk", W'(lrclk), 16'd0);
        run_to(391);

`ifdef I2S_RX_PEAK_EN
        fl[0] = 16'h8000; fr[0] = 16'h0100;
        fl[1] = 16'h0200; fr[1] = 16'hFD00;
        fl[2] = 16'h0010; fr[2] = 16'hFFE0;
        en = 1'b0;
        peak_clr = 1'b1;
        cycle();
        peak_clr = 1'b0;
        en = 1'b1;
        chk("peak_cleared", peak, 16'h0000);
        run_to(902);
        chk("peak_max", peak, 16'h7FFF);
        peak_clr = 1'b1;
        cycle();
        peak_clr = 1'b0;
        chk("peak_clr", peak, 16'h0000);
        run_to(1414);
        chk("peak_new", peak, 16'h0020);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
